fetch_ctrl: RTL

Next-PC sequencer and instruction-memory handshake controller for the IF stage. It computes the next fetch address `pcadd` and the fetch stall `stallf`, which the IF PC register consumes. It owns the imem req/ack handshake and holds branch/jump/exception redirects that arrive while a fetch is outstanding. It asserts a one-cycle decode flush whenever a redirect takes effect.

---
 rtl/fetch_pkg.sv | 50 +++++
 rtl/fetch_ctrl_redirect_hold.sv | 48 ++++
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the IF next-PC sequencer.
// State encoding, redirect causes and the redirect priority picker.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_BRANCH = 2'd1,
    C_JUMP   = 2'd2,
    C_EXC    = 2'd3
  } cause_e;

  typedef struct packed {
    cause_e      cause;
    logic [31:0] target;
  } redir_t;

  localparam logic [31:0] PC_INC = 32'd4;

  // Cause values are ordered so a numerically larger cause wins.
  function automatic redir_t pick_redir(
    input logic        exc,
    input logic        jmp,
    input logic [31:0] jt,
    input logic        br,
    input logic [31:0] bt,
    input logic [31:0] ev
  );
    redir_t r;
    r.cause  = C_NONE;
    r.target = '0;
    if (exc) begin
      r.cause  = C_EXC;
      r.target = ev;
    end else if (jmp) begin
      r.cause  = C_JUMP;
      r.target = jt;
    end else if (br) begin
      r.cause  = C_BRANCH;
      r.target = bt;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_hold.sv
// Pending-redirect register for fetch_ctrl.
// Keeps the highest-priority redirect seen while IF is stalled.
module redirect_hold
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        clear,
  input  logic        exc_req,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        pend_valid,
  output logic [31:0] pend_target
);

  redir_t in_r;
  cause_e pend_cause;
  logic   load;

  always_comb begin
    in_r = pick_redir(exc_req, jump, jump_target,
                      branch_taken, branch_target,
                      EXC_VECTOR);
    load = capture && (in_r.cause != C_NONE) &&
           (!pend_valid || (in_r.cause >= pend_cause));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_cause  <= C_NONE;
      pend_target <= '0;
    end else if (clear) begin
      pend_valid  <= 1'b0;
      pend_cause  <= C_NONE;
    end else if (load) begin
      pend_valid  <= 1'b1;
      pend_cause  <= in_r.cause;
      pend_target <= in_r.target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF next-PC sequencer and imem req/ack controller.
// Optional macro FETCH_PERF_CNT_EN adds stall/redirect counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h00100008,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180,
  parameter int          MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcfetch,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pcadd,
  output logic        stallf,
  output logic        flushd,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects,
`endif
  output logic        imem_timeout
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_e      state, state_nxt;
  logic [7:0]  wait_cnt, cnt_nxt;
  logic        pend_valid;
  logic [31:0] pend_target;
  redir_t      live;
  logic [31:0] npc;
  logic        redir_hit;
  logic        apply;
  logic        tmo;
  logic        capture;
  logic        redirected;

  redirect_hold #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_hold (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture),
    .clear        (apply | tmo),
    .exc_req      (exc_req),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pend_valid   (pend_valid),
    .pend_target  (pend_target)
  );

  always_comb begin
    live = pick_redir(exc_req, jump, jump_target,
                      branch_taken, branch_target,
                      EXC_VECTOR);
    redir_hit = pend_valid || (live.cause != C_NONE);
    if (live.cause == C_EXC)
      npc = EXC_VECTOR;
    else if (pend_valid)
      npc = pend_target;
    else if (live.cause != C_NONE)
      npc = live.target;
    else
      npc = pcfetch + PC_INC;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    imem_req  = 1'b0;
    stallf    = 1'b0;
    pcadd     = pcfetch;
    apply     = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      BOOT: begin
        pcadd     = RESET_PC;
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (hazard_stall) begin
          stallf = 1'b1;
        end else if (imem_ack) begin
          pcadd = npc;
          apply = 1'b1;
        end else begin
          stallf    = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = 8'd1;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (!imem_ack && wait_cnt == MAX_W) begin
          tmo       = 1'b1;
          pcadd     = EXC_VECTOR;
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end else if (imem_ack) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
          if (hazard_stall) begin
            stallf = 1'b1;
          end else begin
            pcadd = npc;
            apply = 1'b1;
          end
        end else begin
          stallf  = 1'b1;
          cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = BOOT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // BOOT has no fetch in flight, so redirects there are held too.
  assign capture    = stallf || (state == BOOT);
  assign redirected = (apply && redir_hit) || tmo;
  assign imem_addr  = pcfetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      wait_cnt     <= '0;
      flushd       <= 1'b0;
      imem_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= cnt_nxt;
      flushd       <= redirected;
      imem_timeout <= tmo;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (stallf && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirected && perf_redirects != '1)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
